hazard_forward_unit: RTL

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

---
 rtl/hazard_forward_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding-select unit for a 5-stage in-order pipeline.
// Define HAZARD_STATS_EN to add stall/flush/forward event counters.
module hazard_forward_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_wr_en,
  input  logic                  id_is_load,
  input  logic                  branch_taken,
  output logic                  stall,
  output logic                  flush,
  output logic                  Forward_1,
  output logic                  Forward_2,
  output logic                  mem_Forward_1,
  output logic                  mem_Forward_2,
  output logic                  wb_Forward_1,
  output logic                  wb_Forward_2
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      fwd_cnt
`endif
);

  // Shadow copies of the producers currently in EX, MEM and WB.
  logic                  ex_valid_q, mem_valid_q, wb_valid_q;
  logic [REG_ADDR_W-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
  logic                  ex_wr_en_q, mem_wr_en_q, wb_wr_en_q;
  logic                  ex_is_load_q, mem_is_load_q, wb_is_load_q;

  logic                  ex_valid_d;
  logic [REG_ADDR_W-1:0] ex_rd_d;
  logic                  ex_wr_en_d, ex_is_load_d;

  logic fwd1_ex_q, fwd1_mem_q, fwd1_wb_q, fwd2_ex_q, fwd2_mem_q, fwd2_wb_q;
  logic fwd1_ex_d, fwd1_mem_d, fwd1_wb_d, fwd2_ex_d, fwd2_mem_d, fwd2_wb_d;

  logic m1_ex, m1_mem, m1_wb, m2_ex, m2_mem, m2_wb;

  function automatic logic slot_match(input logic                  v,
                                      input logic                  we,
                                      input logic [REG_ADDR_W-1:0] rd,
                                      input logic                  use_src,
                                      input logic [REG_ADDR_W-1:0] src);
    return v & we & (rd != '0) & use_src & (src == rd);
  endfunction

  always_comb begin
    m1_ex  = slot_match(ex_valid_q,  ex_wr_en_q,  ex_rd_q,  id_use_rs, id_rs);
    m1_mem = slot_match(mem_valid_q, mem_wr_en_q, mem_rd_q, id_use_rs, id_rs);
    m1_wb  = slot_match(wb_valid_q,  wb_wr_en_q,  wb_rd_q,  id_use_rs, id_rs);
    m2_ex  = slot_match(ex_valid_q,  ex_wr_en_q,  ex_rd_q,  id_use_rt, id_rt);
    m2_mem = slot_match(mem_valid_q, mem_wr_en_q, mem_rd_q, id_use_rt, id_rt);
    m2_wb  = slot_match(wb_valid_q,  wb_wr_en_q,  wb_rd_q,  id_use_rt, id_rt);

    flush = branch_taken & ~rst;
    stall = id_valid & ex_is_load_q & (m1_ex | m2_ex) & ~flush & ~rst;

    // Nearest producer wins; a stall or flush kills every select.
    fwd1_ex_d  = 1'b0;
    fwd1_mem_d = 1'b0;
    fwd1_wb_d  = 1'b0;
    fwd2_ex_d  = 1'b0;
    fwd2_mem_d = 1'b0;
    fwd2_wb_d  = 1'b0;
    if (!(stall || flush)) begin
      fwd1_ex_d  = m1_ex;
      fwd1_mem_d = ~m1_ex & m1_mem;
      fwd1_wb_d  = ~m1_ex & ~m1_mem & m1_wb;
      fwd2_ex_d  = m2_ex;
      fwd2_mem_d = ~m2_ex & m2_mem;
      fwd2_wb_d  = ~m2_ex & ~m2_mem & m2_wb;
    end

    ex_valid_d   = id_valid & ~stall & ~flush;
    ex_rd_d      = id_rd;
    ex_wr_en_d   = id_wr_en;
    ex_is_load_d = id_is_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      mem_valid_q   <= 1'b0;
      wb_valid_q    <= 1'b0;
      ex_rd_q       <= '0;
      mem_rd_q      <= '0;
      wb_rd_q       <= '0;
      ex_wr_en_q    <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      wb_wr_en_q    <= 1'b0;
      ex_is_load_q  <= 1'b0;
      mem_is_load_q <= 1'b0;
      wb_is_load_q  <= 1'b0;
      fwd1_ex_q     <= 1'b0;
      fwd1_mem_q    <= 1'b0;
      fwd1_wb_q     <= 1'b0;
      fwd2_ex_q     <= 1'b0;
      fwd2_mem_q    <= 1'b0;
      fwd2_wb_q     <= 1'b0;
    end else begin
      wb_valid_q    <= mem_valid_q;
      wb_rd_q       <= mem_rd_q;
      wb_wr_en_q    <= mem_wr_en_q;
      wb_is_load_q  <= mem_is_load_q;
      mem_valid_q   <= ex_valid_q;
      mem_rd_q      <= ex_rd_q;
      mem_wr_en_q   <= ex_wr_en_q;
      mem_is_load_q <= ex_is_load_q;
      ex_valid_q    <= ex_valid_d;
      ex_rd_q       <= ex_rd_d;
      ex_wr_en_q    <= ex_wr_en_d;
      ex_is_load_q  <= ex_is_load_d;
      fwd1_ex_q     <= fwd1_ex_d;
      fwd1_mem_q    <= fwd1_mem_d;
      fwd1_wb_q     <= fwd1_wb_d;
      fwd2_ex_q     <= fwd2_ex_d;
      fwd2_mem_q    <= fwd2_mem_d;
      fwd2_wb_q     <= fwd2_wb_d;
    end
  end

  assign Forward_1     = fwd1_ex_q;
  assign mem_Forward_1 = fwd1_mem_q;
  assign wb_Forward_1  = fwd1_wb_q;
  assign Forward_2     = fwd2_ex_q;
  assign mem_Forward_2 = fwd2_mem_q;
  assign wb_Forward_2  = fwd2_wb_q;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, fwd_cnt_q;
  logic             any_fwd_d;

  assign any_fwd_d = fwd1_ex_d | fwd1_mem_d | fwd1_wb_d | fwd2_ex_d | fwd2_mem_d | fwd2_wb_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall)     stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush)     flush_cnt_q <= flush_cnt_q + 1'b1;
      if (any_fwd_d) fwd_cnt_q   <= fwd_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule
